// File: rtl/camera_emulator.sv
// Sensor-style frame generator: emits FRAME_VALID/LINE_VALID/DATA_OUT timing
// like a parallel CMOS sensor, with four selectable test patterns, a
// frame-done pulse and a wrapping completed-frame counter.
module camera_emulator #(
  parameter int H        = 752,
  parameter int V        = 480,
  parameter int HB       = 94,
  parameter int FV_LEAD  = 2,
  parameter int FV_TRAIL = 2,
  parameter int VB       = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic [1:0] MODE,
  output logic       FRAME_VALID,
  output logic       LINE_VALID,
  output logic [9:0] DATA_OUT,
  output logic       FRAME_DONE,
  output logic [7:0] FRAME_COUNT
);

  localparam int CW    = (H > 1) ? $clog2(H) : 1;
  localparam int LW    = (V > 1) ? $clog2(V) : 1;
  localparam int BMAX1 = (HB > FV_LEAD) ? HB : FV_LEAD;
  localparam int BMAX2 = (FV_TRAIL > VB) ? FV_TRAIL : VB;
  localparam int BMAX  = (BMAX1 > BMAX2) ? BMAX1 : BMAX2;
  localparam int BW    = (BMAX > 1) ? $clog2(BMAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    ACTIVE,
    HBLANK,
    TRAIL,
    VBLANK
  } state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [LW-1:0]   line;
  logic [BW-1:0]   cnt;
  logic [1:0]      mode_r;

  // Pattern value for a pixel position; operands arrive zero-extended to 10 bits.
  function automatic logic [9:0] pix(input logic [1:0] m, input logic [9:0] c,
                                     input logic [9:0] l, input logic [9:0] f);
    case (m)
      2'd0:    pix = c;
      2'd1:    pix = l;
      2'd2:    pix = {10{c[3] ^ l[3]}};
      default: pix = c + l + f;
    endcase
  endfunction

  // Frame timing FSM; outputs are assigned on the transition into the cycle
  // they describe, so every output is a plain register aligned with state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      col         <= '0;
      line        <= '0;
      cnt         <= '0;
      mode_r      <= '0;
      FRAME_VALID <= 1'b0;
      LINE_VALID  <= 1'b0;
      DATA_OUT    <= '0;
      FRAME_DONE  <= 1'b0;
      FRAME_COUNT <= '0;
    end else begin
      FRAME_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (ENABLE) begin
            state       <= LEAD;
            cnt         <= '0;
            mode_r      <= MODE;
            FRAME_VALID <= 1'b1;
          end
        end
        LEAD: begin
          if (cnt == BW'(FV_LEAD - 1)) begin
            state      <= ACTIVE;
            cnt        <= '0;
            col        <= '0;
            line       <= '0;
            LINE_VALID <= 1'b1;
            DATA_OUT   <= pix(mode_r, 10'd0, 10'd0, 10'(FRAME_COUNT));
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACTIVE: begin
          if (col == CW'(H - 1)) begin
            LINE_VALID <= 1'b0;
            DATA_OUT   <= '0;
            cnt        <= '0;
            state      <= (line == LW'(V - 1)) ? TRAIL : HBLANK;
          end else begin
            col      <= col + 1'b1;
            DATA_OUT <= pix(mode_r, 10'(col + 1'b1), 10'(line), 10'(FRAME_COUNT));
          end
        end
        HBLANK: begin
          if (cnt == BW'(HB - 1)) begin
            state      <= ACTIVE;
            cnt        <= '0;
            col        <= '0;
            line       <= line + 1'b1;
            LINE_VALID <= 1'b1;
            DATA_OUT   <= pix(mode_r, 10'd0, 10'(line + 1'b1), 10'(FRAME_COUNT));
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TRAIL: begin
          if (cnt == BW'(FV_TRAIL - 1)) begin
            state       <= VBLANK;
            cnt         <= '0;
            FRAME_VALID <= 1'b0;
            FRAME_DONE  <= 1'b1;
            FRAME_COUNT <= FRAME_COUNT + 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        VBLANK: begin
          if (cnt == BW'(VB - 1)) begin
            cnt <= '0;
            if (ENABLE) begin
              state       <= LEAD;
              mode_r      <= MODE;
              FRAME_VALID <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/camera_emulator.md
CAMERA_EMULATOR -- requirements
Module: camera_emulator

Interface
REQ-001 Parameter H, 752: active pixels per line.
REQ-002 Parameter V, 480: active lines per frame.
REQ-003 Parameter HB, 94: horizontal blanking cycles between lines (LV low, FV high).
REQ-004 Parameter FV_LEAD, 2: cycles of FV high before the first LV of a frame.
REQ-005 Parameter FV_TRAIL, 2: cycles of FV high after the last LV of a frame.
REQ-006 Parameter VB, 1000: cycles of FV low between frames.
REQ-007 Port CLK  input  1  sole clock; one pixel per rising edge; the board drives the sensor-side PIXCLK from CLK.
REQ-008 Port RST  input  1  reset, synchronous, active-high.
REQ-009 Port ENABLE  input  1  level; run frames continuously while high.
REQ-010 Port MODE  input  2  test pattern select; sampled at frame start.
REQ-011 Port FRAME_VALID  output  1  registered sensor-style frame strobe.
REQ-012 Port LINE_VALID  output  1  registered sensor-style line strobe.
REQ-013 Port DATA_OUT  output  10  registered pixel value.
REQ-014 Port FRAME_DONE  output  1  one-cycle pulse at FRAME_VALID fall.
REQ-015 Port FRAME_COUNT  output  8  completed-frame counter, wraps 255->0.

Function
REQ-016 States: IDLE, LEAD, ACTIVE, HBLANK, TRAIL, VBLANK; all outputs registered, no combinational path from inputs to outputs.
REQ-017 IDLE: FV=0, LV=0, DATA_OUT=0; ENABLE sampled high -> LEAD, FV=1 on the following cycle; MODE latched into an internal register on that transition.
REQ-018 LEAD: FV=1, LV=0 for exactly FV_LEAD cycles -> ACTIVE, line=0, column=0.
REQ-019 ACTIVE: FV=1, LV=1 for exactly H cycles, column 0..H-1; then HBLANK if line<V-1, else TRAIL.
REQ-020 HBLANK: FV=1, LV=0 for exactly HB cycles; line increments by 1, column resets to 0 -> ACTIVE.
REQ-021 TRAIL: FV=1, LV=0 for exactly FV_TRAIL cycles -> VBLANK; FV falls on the first VBLANK cycle.
REQ-022 FRAME_DONE=1 in the same cycle FV first reads 0 after a frame; FRAME_COUNT increments in that same cycle.
REQ-023 VBLANK: FV=0 for exactly VB cycles; at end, ENABLE high -> LEAD (re-latch MODE), else IDLE.
REQ-024 ENABLE falling mid-frame does not truncate: the current frame and its VBLANK complete in full.
REQ-025 FV high duration per frame = FV_LEAD + V*H + (V-1)*HB + FV_TRAIL cycles exactly.
REQ-026 DATA_OUT = 0 whenever LV=0.
REQ-027 DATA_OUT while LV=1, per latched mode, result truncated to 10 bits:
 - 0: column[9:0].
 - 1: line zero-extended to 10 bits.
 - 2: 10'h3FF if column[3]^line[3], else 0.
 - 3: (column + line + FRAME_COUNT) mod 1024.
REQ-028 Column counter width $clog2(H); line counter width $clog2(V); blanking counters sized to their largest parameter.
REQ-029 MODE changes mid-frame have no effect until the next LEAD entry.

Reset
REQ-030 RST=1 at any clock edge, including mid-line: next cycle FV=0, LV=0, DATA_OUT=0, FRAME_DONE=0, FRAME_COUNT=0, state IDLE, all counters 0, latched mode 0.
REQ-031 RST has priority over ENABLE; with ENABLE held high, LEAD begins on the first cycle after RST deasserts.

Verification (H=4, V=3, HB=2, FV_LEAD=1, FV_TRAIL=1, VB=3)
REQ-032 ENABLE=1, MODE=0 -> FV high exactly 18 cycles; LV pulses 4,4,4 separated by 2 low cycles; DATA_OUT per line 0,1,2,3.
REQ-033 MODE=1, single frame (ENABLE dropped during frame) -> line data 0,0,0,0 / 1,1,1,1 / 2,2,2,2; FRAME_DONE single pulse; FRAME_COUNT=1; FSM returns to IDLE after 3 VBLANK cycles.
REQ-034 ENABLE held high, MODE=3 -> second frame line 0 reads 1,2,3,4; FV low exactly 3 cycles between frames.
REQ-035 RST asserted during second ACTIVE line -> outputs and FRAME_COUNT 0 next cycle; no FRAME_DONE pulse.
REQ-036 Loopback: emulator outputs drive the camera capture block -> captured pixel count per frame = 12, line/column indices match the generated pattern.
REQ-037 Run 256 frames -> FRAME_COUNT wraps to 0 on the 256th FRAME_DONE.
